// File: rtl/spram_ctrl.sv
// rtl/spram_ctrl.sv - single-port RAM request controller with clear sweep and fixed-latency read responses
// Owns the spram port: sweeps it to clear_value after reset or on clear, then serves in-order requests.
module spram_ctrl #(
  parameter int                    address_width = 10,
  parameter int                    data_width    = 8,
  parameter logic [data_width-1:0] clear_value   = '0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  output logic                     busy,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [address_width-1:0] req_address,
  input  logic [data_width-1:0]    req_data,
  output logic                     rsp_valid,
  output logic [data_width-1:0]    rsp_data,
  output logic                     ram_wren,
  output logic [address_width-1:0] ram_address,
  output logic [data_width-1:0]    ram_data,
  input  logic [data_width-1:0]    ram_q
);

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_IDLE  = 1'b1;

  logic                     state_q, state_d;
  logic [address_width-1:0] count_q, count_d;
  logic                     wren_q, wren_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [data_width-1:0]    data_q, data_d;
  logic [1:0]               pend_q, pend_d;
  logic                     accept;

  assign busy      = (state_q == ST_CLEAR);
  assign req_ready = (state_q == ST_IDLE) && !clear;
  assign accept    = req_valid && req_ready;

  assign ram_wren    = wren_q;
  assign ram_address = addr_q;
  assign ram_data    = data_q;

  // The RAM output is registered inside spram, so q is already aligned with stage 2.
  assign rsp_valid = pend_q[1];
  assign rsp_data  = ram_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (state_q == ST_CLEAR) begin
      wren_d  = 1'b1;
      addr_d  = count_q;
      data_d  = clear_value;
      count_d = count_q + 1'b1;
      if (&count_q) begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    end else begin
      if (accept) begin
        wren_d = req_write;
        addr_d = req_address;
        if (req_write) begin
          data_d = req_data;
        end
      end
      if (clear) begin
        state_d = ST_CLEAR;
      end
    end
  end

  assign pend_d = {pend_q[0], accept && !req_write};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      count_q <= '0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_spram_ctrl.sv
// tb/tb_spram_ctrl.sv - randomized self-checking bench for spram_ctrl against a memory/response model
module tb_spram_ctrl;

  localparam int          AW = 4;
  localparam int          DW = 8;
  localparam int          DEPTH = 1 << AW;
  localparam logic [7:0]  CV = 8'hA5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          busy;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_address = '0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          ram_wren;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;

  spram_ctrl #(
    .address_width(AW),
    .data_width   (DW),
    .clear_value  (CV)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .busy       (busy),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_address(req_address),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .ram_wren   (ram_wren),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_q      (ram_q)
  );

  always #5 clock = ~clock;

  // spram: registered read-first output
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Model: memory contents as seen by in-order requests, expected RAM port, response schedule.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] ref_mem [DEPTH];
  rsp_t          rq[$];
  int            sweep_start = -1000;
  logic          e_wren = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;

  function automatic bit in_sweep(input int c);
    return (c >= sweep_start) && (c < sweep_start + DEPTH);
  endfunction

  task automatic plan(input bit acc, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (in_sweep(cyc)) begin
      e_wren = 1'b1;
      e_addr = AW'(cyc - sweep_start);
      e_data = CV;
    end else if (acc) begin
      e_wren = wr;
      e_addr = a;
      if (wr) e_data = d;
    end else begin
      e_wren = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("busy", {31'd0, busy}, {31'd0, in_sweep(cyc)});
    check("ram_wren", {31'd0, ram_wren}, {31'd0, e_wren});
    check("ram_address", {28'd0, ram_address}, {28'd0, e_addr});
    check("ram_data", {24'd0, ram_data}, {24'd0, e_data});
    if (rq.size() > 0 && rq[0].due == cyc) begin
      check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("rsp_data", {24'd0, rsp_data}, {24'd0, rq[0].data});
      void'(rq.pop_front());
    end else begin
      check("rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  task automatic tick(input logic clr, input logic vld, input logic wr,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit exp_ready;
    bit acc;
    @(negedge clock);
    check_outputs();
    clear = clr;
    req_valid = vld;
    req_write = wr;
    req_address = a;
    req_data = d;
    #1;
    exp_ready = !in_sweep(cyc) && !clr;
    check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    acc = vld && exp_ready;
    plan(acc, wr, a, d);
    if (acc && wr) ref_mem[a] = d;
    if (acc && !wr) rq.push_back('{due: cyc + 2, data: ref_mem[a]});
    if (!in_sweep(cyc) && clr) begin
      sweep_start = cyc + 1;
      foreach (ref_mem[i]) ref_mem[i] = CV;
    end
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset_n = 1'b1;
    sweep_start = cyc;
    foreach (ref_mem[i]) ref_mem[i] = CV;
    plan(1'b0, 1'b0, '0, '0);
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    check_outputs();
    reset_n = 1'b0;
    clear = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rst ram_wren", {31'd0, ram_wren}, 32'd0);
    check("rst ram_address", {28'd0, ram_address}, 32'd0);
    check("rst ram_data", {24'd0, ram_data}, 32'd0);
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd1);
    check("rst req_ready", {31'd0, req_ready}, 32'd0);
    rq.delete();
    e_wren = 1'b0;
    e_addr = '0;
    e_data = '0;
    sweep_start = -1000;
    release_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tick(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    tick(1'b0, 1'b1, 1'b0, a, '0);
  endtask

  initial begin
    #1;
    check("por busy", {31'd0, busy}, 32'd1);
    check("por req_ready", {31'd0, req_ready}, 32'd0);
    repeat (3) @(negedge clock);
    release_reset();
    idle(16);
    rd(4'd0); rd(4'd7); rd(4'd15);
    idle(3);

    wr(4'd5, 8'h3C); rd(4'd5);
    idle(3);

    wr(4'd1, 8'h11); wr(4'd2, 8'h22); wr(4'd3, 8'h33);
    rd(4'd1); rd(4'd2); rd(4'd3);
    idle(3);

    tick(1'b1, 1'b1, 1'b1, 4'd9, 8'h5A);
    idle(17);
    rd(4'd9);
    idle(3);

    wr(4'd4, 8'h77); rd(4'd4);
    tick(1'b1, 1'b0, 1'b0, '0, '0);
    idle(18);

    rd(4'd3);
    tick(1'b1, 1'b0, 1'b0, '0, '0);
    idle(6);
    reset_pulse();
    idle(18);

    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spram_ctrl.md
# spram_ctrl

Request-side controller that owns the single port of a `spram` instance and is the only block that drives it. Clients issue reads and writes over a valid/ready request channel; the controller registers them onto the RAM port and returns read data on a fixed-latency response channel. After reset, or on command, it sweeps the whole array to a fill value before accepting traffic.

## Interface
Parameters:
- `address_width`, 10: RAM address width; array depth is 2**address_width.
- `data_width`, 8: RAM word width.
- `clear_value`, 0: word written to every location during a clear sweep (`data_width` bits).

Ports:
- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  single-cycle request to start a clear sweep.
- `busy`  out  1  high while a clear sweep is in progress.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high together with `req_valid`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_address`  in  `address_width`  target address.
- `req_data`  in  `data_width`  write data; ignored for reads.
- `rsp_valid`  out  1  `rsp_data` carries read data this cycle.
- `rsp_data`  out  `data_width`  read data.
- `ram_wren`  out  1  to `spram.wren`.
- `ram_address`  out  `address_width`  to `spram.address`.
- `ram_data`  out  `data_width`  to `spram.data`.
- `ram_q`  in  `data_width`  from `spram.q`.

## Operation
- Two states: CLEAR and IDLE. Reset enters CLEAR with the sweep counter at 0.
- CLEAR:
  - Each cycle registers `ram_wren`=1, `ram_address`=counter, `ram_data`=`clear_value`, then increments the counter.
  - After the edge that issues address 2**address_width-1, the state moves to IDLE and the counter returns to 0.
  - The `clear` input is ignored; the sweep is never restarted or extended.
- IDLE:
  - `req_ready` = (state==IDLE) && !`clear`, combinational.
  - On acceptance, the request is registered onto `ram_wren`/`ram_address`/`ram_data`. `ram_wren`=`req_write`, and `ram_data`=`req_data` for writes.
  - With no acceptance, `ram_wren` registers 0 and `ram_address`/`ram_data` hold their values.
  - `clear` high enters CLEAR at the next edge. A `req_valid` in the same cycle is not accepted and must be held by the client.
- `busy` = (state==CLEAR), combinational.
- Response path:
  - A one-bit read-pending pipeline (2 stages) tracks accepted reads. `rsp_valid` is the stage-2 output.
  - `rsp_data` = `ram_q` passed through combinationally; it is undefined when `rsp_valid`=0.
  - There is no response backpressure.
  - Reads accepted before a clear still produce their responses while the sweep runs.
- Accesses are strictly in order, at most one per cycle. The single RAM port makes simultaneous read and write impossible.

## Timing
- Reset values: `ram_wren`=0, `ram_address`=0, `ram_data`=0, `rsp_valid`=0. During reset, `busy`=1 and `req_ready`=0.
- Reset asserted mid-sweep or mid-read aborts everything:
  - The pending pipeline clears and no response is produced.
  - The sweep restarts from 0 after release.
- Clear sweep length: exactly 2**address_width cycles of `ram_wren`=1.
  - At `address_width`=10, the first edge after release issues address 0 and edge 1024 issues address 1023.
  - `busy` falls and `req_ready` rises in the cycle after edge 1024.
- Read latency: request accepted at edge E0; `ram_address` valid in cycle 1; RAM samples at E1; `rsp_valid`=1 with data in cycle 2.
- Write: reaches the RAM at E1 after acceptance at E0.
- Read-after-write to the same address accepted on the next cycle returns the new data.
- Full throughput: one request accepted per cycle indefinitely in IDLE with `clear`=0.

## Test plan
- Reset release, `address_width`=4, `clear_value`=8'hA5 → 16 consecutive cycles with `ram_wren`=1 at addresses 0..15, `busy`=1 throughout; then `req_ready`=1; reads of addresses 0, 7 and 15 each return 8'hA5 two cycles after acceptance.
- Write 8'h3C to address 5, then read address 5 on the next cycle → `rsp_valid`=1 exactly 2 cycles after the read acceptance with `rsp_data`=8'h3C.
- Back-to-back reads of addresses 1, 2, 3 after writing 8'h11/8'h22/8'h33 → `rsp_valid` high for 3 consecutive cycles with data 11, 22, 33 in order.
- `clear` and `req_valid` (write to address 9) asserted in the same IDLE cycle → `req_ready`=0, the write is not issued, `busy` rises next cycle, and after the sweep address 9 reads `clear_value`.
- Read accepted in the cycle before `clear` → its response still arrives 2 cycles later with the pre-clear data, while `busy`=1.
- `reset_n` pulsed low during a sweep at counter 6 → outputs return to reset values immediately, and the sweep restarts at address 0 after release.
